mem_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory of the multicycle core between the CPU and a DMA/loader port.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arb_lat_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and grant helpers for the CPU/DMA unified-memory arbiter.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CPU  = 2'b01;
  localparam logic [1:0] OWNER_DMA  = 2'b10;

  // CPU wins contention until its run budget is spent, then DMA is forced.
  function automatic logic [1:0] grant_sel(input logic cpu_req,
                                           input logic dma_req,
                                           input logic run_full);
    if (cpu_req && (!dma_req || !run_full)) begin
      return OWNER_CPU;
    end else if (dma_req) begin
      return OWNER_DMA;
    end
    return OWNER_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's req/ready access port; the arbiter takes the slave side.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ready;

  modport master (
    output req,
    output we,
    output adr,
    output wdata,
    input  rdata,
    input  ready
  );

  modport slave (
    input  req,
    input  we,
    input  adr,
    input  wdata,
    output rdata,
    output ready
  );
endinterface

// File: rtl/mem_arb_lat_cnt.sv
// Access-latency counter: held at zero by load, counts while enabled, flags the last access cycle.
module mem_arb_lat_cnt #(
  parameter int MEM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_done = i_count && w_last;

  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_cnt <= '0;
    end else if (i_count && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port unified memory between CPU and DMA: fixed CPU priority with a
// starvation limit, every access sequenced IDLE -> ACC (MEM_LAT cycles) -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 1,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  cpu_bus,
  mem_arbiter_if.slave  dma_bus,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic [1:0]    owner
);
  localparam int RW = $clog2(MAX_CPU_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_CPU_RUN);

  logic [1:0]    r_state;
  logic [1:0]    r_owner;
  logic          r_we;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [RW-1:0] r_run_cnt;

  logic [1:0]    w_grant;
  logic          w_run_full;
  logic          w_done;
  logic          w_in_acc;
  logic          w_in_resp;
  logic          w_cpu_ready;
  logic          w_dma_ready;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_adr;
  logic [DW-1:0] w_sel_wdata;
  logic [RW-1:0] w_run_next;

  assign w_in_acc   = (r_state == ST_ACC);
  assign w_in_resp  = (r_state == ST_RESP);
  assign w_run_full = (r_run_cnt >= RUN_MAX);
  assign w_grant    = (r_state == ST_IDLE) ?
                      grant_sel(cpu_bus.req, dma_bus.req, w_run_full) : OWNER_NONE;

  always_comb begin
    w_sel_we    = cpu_bus.we;
    w_sel_adr   = cpu_bus.adr;
    w_sel_wdata = cpu_bus.wdata;
    if (w_grant == OWNER_DMA) begin
      w_sel_we    = dma_bus.we;
      w_sel_adr   = dma_bus.adr;
      w_sel_wdata = dma_bus.wdata;
    end
  end

  // Only contended CPU grants consume the run budget; anything else refills it.
  always_comb begin
    w_run_next = r_run_cnt;
    if (w_grant == OWNER_DMA || (w_grant == OWNER_CPU && !dma_bus.req)) begin
      w_run_next = '0;
    end else if (w_grant == OWNER_CPU && !w_run_full) begin
      w_run_next = r_run_cnt + RW'(1);
    end
  end

  mem_arb_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (!w_in_acc),
    .i_count (w_in_acc),
    .o_done  (w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_owner   <= OWNER_NONE;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_run_cnt <= '0;
    end else begin
      r_run_cnt <= w_run_next;
      case (r_state)
        ST_IDLE: begin
          if (w_grant != OWNER_NONE) begin
            r_owner <= w_grant;
            r_we    <= w_sel_we;
            r_adr   <= w_sel_adr;
            r_wdata <= w_sel_wdata;
            r_state <= ST_ACC;
          end
        end
        ST_ACC: begin
          // Writes capture mem_rd too, so the completion path is uniform.
          if (w_done) begin
            r_rdata <= mem_rd;
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_owner <= OWNER_NONE;
          r_state <= ST_IDLE;
        end
        default: begin
          r_owner <= OWNER_NONE;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_en  = w_in_acc;
  assign mem_we  = w_in_acc & r_we;
  assign mem_adr = r_adr;
  assign mem_wd  = r_wdata;
  assign owner   = r_owner;

  assign w_cpu_ready   = w_in_resp && (r_owner == OWNER_CPU);
  assign w_dma_ready   = w_in_resp && (r_owner == OWNER_DMA);
  assign cpu_bus.ready = w_cpu_ready;
  assign dma_bus.ready = w_dma_ready;
  assign cpu_bus.rdata = w_cpu_ready ? r_rdata : '0;
  assign dma_bus.rdata = w_dma_ready ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances (MEM_LAT 1/2/3), scoreboard on the MEM_LAT=1 one.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk;
  logic rst1, rst2, rst3;
  int   n_tests;
  int   n_fail;

  typedef struct {
    logic [1:0]  who;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb_q[$];

  mem_arbiter_if #(.AW(32), .DW(32)) cpu_if1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) dma_if1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) cpu_if2 ();
  mem_arbiter_if #(.AW(32), .DW(32)) dma_if2 ();
  mem_arbiter_if #(.AW(32), .DW(32)) cpu_if3 ();
  mem_arbiter_if #(.AW(32), .DW(32)) dma_if3 ();

  logic        mem_en1, mem_we1, mem_en2, mem_we2, mem_en3, mem_we3;
  logic [31:0] mem_adr1, mem_wd1, mem_rd1;
  logic [31:0] mem_adr2, mem_wd2, mem_rd2;
  logic [31:0] mem_adr3, mem_wd3, mem_rd3;
  logic [1:0]  owner1, owner2, owner3;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  assign mem_rd1 = mem_model(mem_adr1);

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_CPU_RUN(4)) u1 (
    .clk(clk), .reset(rst1), .cpu_bus(cpu_if1), .dma_bus(dma_if1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_adr(mem_adr1), .mem_wd(mem_wd1),
    .mem_rd(mem_rd1), .owner(owner1)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_CPU_RUN(4)) u2 (
    .clk(clk), .reset(rst2), .cpu_bus(cpu_if2), .dma_bus(dma_if2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_adr(mem_adr2), .mem_wd(mem_wd2),
    .mem_rd(mem_rd2), .owner(owner2)
  );

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_CPU_RUN(4)) u3 (
    .clk(clk), .reset(rst3), .cpu_bus(cpu_if3), .dma_bus(dma_if3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_adr(mem_adr3), .mem_wd(mem_wd3),
    .mem_rd(mem_rd3), .owner(owner3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard whenever instance u1 completes an access.
  task automatic mon1();
    sb_t         e;
    logic [31:0] rd_own;
    logic [31:0] rd_other;
    if (cpu_if1.ready === 1'b1 || dma_if1.ready === 1'b1) begin
      n_tests++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow: observed ready cpu=%b dma=%b expected no completion",
               cpu_if1.ready, dma_if1.ready);
      end
      if (sb_q.size() != 0) begin
        e        = sb_q.pop_front();
        rd_own   = (e.who == OWNER_CPU) ? cpu_if1.rdata : dma_if1.rdata;
        rd_other = (e.who == OWNER_CPU) ? dma_if1.rdata : cpu_if1.rdata;
        chk("u1_who", {30'd0, dma_if1.ready, cpu_if1.ready}, {30'd0, e.who});
        chk("u1_rdata", rd_own, e.rdata);
        chk("u1_other_rdata", rd_other, 32'd0);
        $display("[TB] u1 txn who=%0d rdata=%h", e.who, rd_own);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon1();
  endtask

  task automatic push(input logic [1:0] who, input logic [31:0] adr);
    sb_t e;
    e.who   = who;
    e.rdata = mem_model(adr);
    sb_q.push_back(e);
  endtask

  logic [31:0] t6_adr [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    cpu_if1.req = 0; cpu_if1.we = 0; cpu_if1.adr = 0; cpu_if1.wdata = 0;
    dma_if1.req = 0; dma_if1.we = 0; dma_if1.adr = 0; dma_if1.wdata = 0;
    cpu_if2.req = 0; cpu_if2.we = 0; cpu_if2.adr = 0; cpu_if2.wdata = 0;
    dma_if2.req = 0; dma_if2.we = 0; dma_if2.adr = 0; dma_if2.wdata = 0;
    cpu_if3.req = 0; cpu_if3.we = 0; cpu_if3.adr = 0; cpu_if3.wdata = 0;
    dma_if3.req = 0; dma_if3.we = 0; dma_if3.adr = 0; dma_if3.wdata = 0;
    mem_rd2 = 32'hDEAD_BEEF;
    mem_rd3 = 32'hCAFE_0003;

    // Reset state
    step(); step();
    chk("rst_owner1", {30'd0, owner1}, {30'd0, OWNER_NONE});
    chk_b("rst_mem_en1", mem_en1, 1'b0);
    chk_b("rst_mem_we1", mem_we1, 1'b0);
    chk_b("rst_cpu_ready1", cpu_if1.ready, 1'b0);
    chk_b("rst_dma_ready1", dma_if1.ready, 1'b0);
    chk("rst_cpu_rdata1", cpu_if1.rdata, 32'd0);
    chk("rst_owner3", {30'd0, owner3}, {30'd0, OWNER_NONE});
    chk_b("rst_mem_en2", mem_en2, 1'b0);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    step();

    // 1: lone CPU read, MEM_LAT=2
    cpu_if2.req = 1; cpu_if2.we = 0; cpu_if2.adr = 32'h100;
    step();
    chk_b("t1_c1_mem_en", mem_en2, 1'b1);
    chk("t1_c1_mem_adr", mem_adr2, 32'h100);
    chk("t1_c1_owner", {30'd0, owner2}, {30'd0, OWNER_CPU});
    chk_b("t1_c1_mem_we", mem_we2, 1'b0);
    step();
    chk_b("t1_c2_mem_en", mem_en2, 1'b1);
    chk_b("t1_c2_cpu_ready", cpu_if2.ready, 1'b0);
    step();
    chk_b("t1_c3_cpu_ready", cpu_if2.ready, 1'b1);
    chk("t1_c3_cpu_rdata", cpu_if2.rdata, 32'hDEAD_BEEF);
    chk_b("t1_c3_dma_ready", dma_if2.ready, 1'b0);
    chk_b("t1_c3_mem_en", mem_en2, 1'b0);
    cpu_if2.req = 0;
    step();
    chk_b("t1_c4_cpu_ready", cpu_if2.ready, 1'b0);
    chk("t1_c4_cpu_rdata", cpu_if2.rdata, 32'd0);
    chk("t1_c4_owner", {30'd0, owner2}, {30'd0, OWNER_NONE});

    // 2: simultaneous requests, MEM_LAT=1
    cpu_if1.req = 1; cpu_if1.we = 0; cpu_if1.adr = 32'h200;
    dma_if1.req = 1; dma_if1.we = 0; dma_if1.adr = 32'h300;
    push(OWNER_CPU, 32'h200);
    push(OWNER_DMA, 32'h300);
    step();
    chk("t2_c1_owner", {30'd0, owner1}, {30'd0, OWNER_CPU});
    chk("t2_c1_mem_adr", mem_adr1, 32'h200);
    step();
    chk_b("t2_c2_cpu_ready", cpu_if1.ready, 1'b1);
    cpu_if1.req = 0;
    step();
    chk("t2_c3_owner", {30'd0, owner1}, {30'd0, OWNER_NONE});
    chk_b("t2_c3_mem_en", mem_en1, 1'b0);
    step();
    chk("t2_c4_owner", {30'd0, owner1}, {30'd0, OWNER_DMA});
    chk("t2_c4_mem_adr", mem_adr1, 32'h300);
    step();
    chk_b("t2_c5_dma_ready", dma_if1.ready, 1'b1);
    chk_b("t2_c5_cpu_ready", cpu_if1.ready, 1'b0);
    dma_if1.req = 0;
    step();

    // 3: both held, starvation limit 4 -> C,C,C,C,D repeating
    cpu_if1.req = 1; cpu_if1.we = 0; cpu_if1.adr = 32'h10;
    dma_if1.req = 1; dma_if1.we = 1; dma_if1.adr = 32'h20; dma_if1.wdata = 32'hA0A0_0001;
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4) push(OWNER_DMA, 32'h20);
      else              push(OWNER_CPU, 32'h10);
    end
    repeat (29) step();
    cpu_if1.req = 0;
    dma_if1.req = 0;
    step(); step();
    chk("t3_sb_left", sb_q.size(), 32'd0);
    chk("t3_owner_idle", {30'd0, owner1}, {30'd0, OWNER_NONE});

    // 4: DMA write, MEM_LAT=3; inputs wiggle during ACC
    dma_if3.req = 1; dma_if3.we = 1; dma_if3.adr = 32'h40; dma_if3.wdata = 32'h1234_5678;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk_b($sformatf("t4_c%0d_mem_en", c), mem_en3, 1'b1);
      chk_b($sformatf("t4_c%0d_mem_we", c), mem_we3, 1'b1);
      chk($sformatf("t4_c%0d_mem_adr", c), mem_adr3, 32'h40);
      chk($sformatf("t4_c%0d_mem_wd", c), mem_wd3, 32'h1234_5678);
      chk_b($sformatf("t4_c%0d_cpu_ready", c), cpu_if3.ready, 1'b0);
      dma_if3.adr = 32'h44; dma_if3.wdata = 32'h0; dma_if3.we = 0;
    end
    step();
    chk_b("t4_dma_ready", dma_if3.ready, 1'b1);
    chk("t4_dma_rdata", dma_if3.rdata, 32'hCAFE_0003);
    chk_b("t4_cpu_ready", cpu_if3.ready, 1'b0);
    dma_if3.req = 0;
    step();
    chk_b("t4_after_dma_ready", dma_if3.ready, 1'b0);

    // 5: reset in first ACC cycle of a CPU read, MEM_LAT=3
    cpu_if3.req = 1; cpu_if3.we = 0; cpu_if3.adr = 32'h80;
    step();
    chk_b("t5_acc_mem_en", mem_en3, 1'b1);
    rst3 = 1'b1;
    step();
    chk("t5_owner", {30'd0, owner3}, {30'd0, OWNER_NONE});
    chk_b("t5_mem_en", mem_en3, 1'b0);
    rst3 = 1'b0;
    cpu_if3.req = 0;
    for (int c = 0; c < 6; c++) begin
      chk_b($sformatf("t5_no_ready_%0d", c), cpu_if3.ready, 1'b0);
      step();
    end

    // 6: CPU back-to-back, address changed after each ready, MEM_LAT=1
    t6_adr[0] = 32'h1000; t6_adr[1] = 32'h2004; t6_adr[2] = 32'h3008; t6_adr[3] = 32'h400C;
    cpu_if1.req = 1; cpu_if1.we = 0; cpu_if1.adr = t6_adr[0];
    for (int i = 0; i < 4; i++) begin
      push(OWNER_CPU, t6_adr[i]);
      step();
      chk($sformatf("t6_%0d_mem_adr", i), mem_adr1, t6_adr[i]);
      chk_b($sformatf("t6_%0d_acc_ready", i), cpu_if1.ready, 1'b0);
      cpu_if1.adr = ~t6_adr[i];
      step();
      chk_b($sformatf("t6_%0d_ready", i), cpu_if1.ready, 1'b1);
      if (i < 3) cpu_if1.adr = t6_adr[i+1];
      else       cpu_if1.req = 0;
      step();
      chk_b($sformatf("t6_%0d_idle_ready", i), cpu_if1.ready, 1'b0);
      chk_b($sformatf("t6_%0d_idle_mem_en", i), mem_en1, 1'b0);
    end
    step();
    chk("t6_sb_left", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
